// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Two-master arbiter sharing one data RAM between the CPU data
//             port (master 0) and a secondary bus master (master 1). Accesses
//             are serialised by an IDLE -> ISSUE -> ACK sequencer; contention
//             in IDLE is resolved round-robin. All outputs are registered.
//  Ports    : clock            - system clock, rising edge
//             reset            - asynchronous reset, active low
//             mX_req/write/addr/wdata/sel - master X request and payload
//             mX_ack           - one-cycle completion pulse
//             mX_rdata         - read data, held until that master's next read
//             ram_read_*       - RAM read port (combinational read data in)
//             ram_write_*      - RAM write port (commits on edge ending strobe)
//  Revision : 1.0  initial release
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,

  input  logic                    m0_req,
  input  logic                    m0_write,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  output logic                    m0_ack,
  output logic [DATA_WIDTH-1:0]   m0_rdata,

  input  logic                    m1_req,
  input  logic                    m1_write,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  output logic                    m1_ack,
  output logic [DATA_WIDTH-1:0]   m1_rdata,

  output logic                    ram_read_enable,
  output logic [ADDR_WIDTH-1:0]   ram_read_address,
  input  logic [DATA_WIDTH-1:0]   ram_read_data,

  output logic                    ram_write_enable,
  output logic [ADDR_WIDTH-1:0]   ram_write_address,
  output logic [DATA_WIDTH-1:0]   ram_write_data,
  output logic [DATA_WIDTH/8-1:0] ram_write_select
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Sequencer state
  // --------------------------------------------------------------------------
  state_t state_q, state_d;
  logic   last_q,  last_d;   // master granted most recently
  logic   owner_q, owner_d;  // master owning the access in flight

  // Output registers
  logic                  m0_ack_q, m1_ack_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;
  logic                  ren_q, wen_q;
  logic [ADDR_WIDTH-1:0] raddr_q, waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SEL_WIDTH-1:0]  wsel_q;

  // Grant decision and selected payload (only meaningful in IDLE)
  logic                  any_req;
  logic                  gnt_m1;
  logic                  gnt_write;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_wdata;
  logic [SEL_WIDTH-1:0]  gnt_sel;

  assign any_req = m0_req | m1_req;
  // Master 1 wins when alone, or on a tie when master 0 was granted last.
  assign gnt_m1    = m1_req & (~m0_req | ~last_q);
  assign gnt_write = gnt_m1 ? m1_write : m0_write;
  assign gnt_addr  = gnt_m1 ? m1_addr  : m0_addr;
  assign gnt_wdata = gnt_m1 ? m1_wdata : m0_wdata;
  assign gnt_sel   = gnt_m1 ? m1_sel   : m0_sel;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;  // master 0 wins the first tie
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = gnt_m1;
          last_d  = gnt_m1;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered datapath. The RAM-side registers are loaded on the grant edge
  // so the strobes are high exactly during the ISSUE cycle; address/data/select
  // keep their last value once the strobes drop.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wsel_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            if (gnt_write) begin
              wen_q   <= 1'b1;
              waddr_q <= gnt_addr;
              wdata_q <= gnt_wdata;
              wsel_q  <= gnt_sel;
            end else begin
              ren_q   <= 1'b1;
              raddr_q <= gnt_addr;
            end
          end
        end
        ISSUE: begin
          ren_q <= 1'b0;
          wen_q <= 1'b0;
          // RAM read data is combinational from the address driven this cycle.
          if (ren_q) begin
            if (owner_q) m1_rdata_q <= ram_read_data;
            else         m0_rdata_q <= ram_read_data;
          end
          if (owner_q) m1_ack_q <= 1'b1;
          else         m0_ack_q <= 1'b1;
        end
        ACK: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
        end
        default: begin
          ren_q    <= 1'b0;
          wen_q    <= 1'b0;
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign m0_ack            = m0_ack_q;
  assign m1_ack            = m1_ack_q;
  assign m0_rdata          = m0_rdata_q;
  assign m1_rdata          = m1_rdata_q;
  assign ram_read_enable   = ren_q;
  assign ram_read_address  = raddr_q;
  assign ram_write_enable  = wen_q;
  assign ram_write_address = waddr_q;
  assign ram_write_data    = wdata_q;
  assign ram_write_select  = wsel_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Directed, table-driven bench for ram_arbiter with a small
//             behavioural RAM (combinational read, byte-enabled clocked write).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_write = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [3:0]  m0_sel = '0;
  logic        m1_req = 1'b0, m1_write = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_sel = '0;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_read_enable, ram_write_enable;
  logic [31:0] ram_read_address, ram_read_data;
  logic [31:0] ram_write_address, ram_write_data;
  logic [3:0]  ram_write_select;

  ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock             (clock),
    .reset             (reset),
    .m0_req            (m0_req),
    .m0_write          (m0_write),
    .m0_addr           (m0_addr),
    .m0_wdata          (m0_wdata),
    .m0_sel            (m0_sel),
    .m0_ack            (m0_ack),
    .m0_rdata          (m0_rdata),
    .m1_req            (m1_req),
    .m1_write          (m1_write),
    .m1_addr           (m1_addr),
    .m1_wdata          (m1_wdata),
    .m1_sel            (m1_sel),
    .m1_ack            (m1_ack),
    .m1_rdata          (m1_rdata),
    .ram_read_enable   (ram_read_enable),
    .ram_read_address  (ram_read_address),
    .ram_read_data     (ram_read_data),
    .ram_write_enable  (ram_write_enable),
    .ram_write_address (ram_write_address),
    .ram_write_data    (ram_write_data),
    .ram_write_select  (ram_write_select)
  );

  always #5 clock = ~clock;

  // Behavioural RAM: 64 words, word-addressed by bits [7:2].
  logic [31:0] mem [0:63];
  assign ram_read_data = mem[ram_read_address[7:2]];
  always @(posedge clock) begin
    if (ram_write_enable) begin
      for (int b = 0; b < 4; b++)
        if (ram_write_select[b]) mem[ram_write_address[7:2]][8*b +: 8] <= ram_write_data[8*b +: 8];
    end
  end

  typedef struct {
    logic r0, w0; logic [31:0] a0, d0; logic [3:0] s0;
    logic r1, w1; logic [31:0] a1, d1; logic [3:0] s1;
    logic ack0, ack1, ren, wen;
    logic [31:0] ea, ed; logic [3:0] es;
    logic [31:0] rd0, rd1;
  } vec_t;

  localparam logic        H   = 1'b1;
  localparam logic        L   = 1'b0;
  localparam logic [31:0] A40 = 32'h40;
  localparam logic [31:0] A44 = 32'h44;
  localparam logic [31:0] DB  = 32'hDEADBEEF;
  localparam logic [31:0] D11 = 32'h11223344;
  localparam logic [31:0] D33 = 32'h00003300;
  localparam logic [31:0] DFF = 32'hFFFFFFFF;
  localparam logic [31:0] Z   = 32'h0;
  localparam logic [3:0]  SF  = 4'hF;
  localparam logic [3:0]  S2  = 4'h2;
  localparam logic [3:0]  S0  = 4'h0;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl [28];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one cycle of inputs, clock once, compare the registered outputs.
  task automatic apply(input string nm, input vec_t v);
    bit ok;
    m0_req = v.r0; m0_write = v.w0; m0_addr = v.a0; m0_wdata = v.d0; m0_sel = v.s0;
    m1_req = v.r1; m1_write = v.w1; m1_addr = v.a1; m1_wdata = v.d1; m1_sel = v.s1;
    tick();
    ok = (m0_ack === v.ack0) && (m1_ack === v.ack1) &&
         (ram_read_enable === v.ren) && (ram_write_enable === v.wen) &&
         (!v.ren || ram_read_address === v.ea) &&
         (!v.wen || (ram_write_address === v.ea && ram_write_data === v.ed &&
                     ram_write_select === v.es)) &&
         (m0_rdata === v.rd0) && (m1_rdata === v.rd1);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got ack0=%b ack1=%b ren=%b wen=%b raddr=%h waddr=%h wdata=%h sel=%h rd0=%h rd1=%h; want ack0=%b ack1=%b ren=%b wen=%b addr=%h wdata=%h sel=%h rd0=%h rd1=%h",
               nm, m0_ack, m1_ack, ram_read_enable, ram_write_enable, ram_read_address,
               ram_write_address, ram_write_data, ram_write_select, m0_rdata, m1_rdata,
               v.ack0, v.ack1, v.ren, v.wen, v.ea, v.ed, v.es, v.rd0, v.rd1);
    end
  endtask

  task automatic check_zero(input string nm);
    logic [229:0] all;
    all = {m0_ack, m1_ack, ram_read_enable, ram_write_enable, m0_rdata, m1_rdata,
           ram_read_address, ram_write_address, ram_write_data, ram_write_select};
    n_vec++;
    if (all !== '0) begin
      n_err++;
      $display("FAIL %s: outputs not all zero, got %h, want 0", nm, all);
    end
  endtask

  vec_t v;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    // m0 write 0x40 / m1 byte write 0x44, both contending
    tbl[0]  = '{H,H,A40,DB,SF, H,H,A44,D11,S2, L,L,L,H, A40,DB,SF, Z,Z};
    tbl[1]  = '{H,H,A40,DB,SF, H,H,A44,D11,S2, H,L,L,L, Z,Z,S0, Z,Z};
    tbl[2]  = '{H,H,A40,DB,SF, H,H,A44,D11,S2, L,L,L,L, Z,Z,S0, Z,Z};
    tbl[3]  = '{L,H,A40,DB,SF, H,H,A44,D11,S2, L,L,L,H, A44,D11,S2, Z,Z};
    tbl[4]  = '{L,H,A40,DB,SF, H,H,A44,D11,S2, L,H,L,L, Z,Z,S0, Z,Z};
    // m0 reads back 0x40
    tbl[5]  = '{H,L,A40,Z,S0, H,H,A44,D11,S2, L,L,L,L, Z,Z,S0, Z,Z};
    tbl[6]  = '{H,L,A40,Z,S0, L,H,A44,D11,S2, L,L,H,L, A40,Z,S0, Z,Z};
    tbl[7]  = '{H,L,A40,Z,S0, L,H,A44,D11,S2, H,L,L,L, Z,Z,S0, DB,Z};
    tbl[8]  = '{H,L,A40,Z,S0, L,H,A44,D11,S2, L,L,L,L, Z,Z,S0, DB,Z};
    // m1 reads back the byte-select word
    tbl[9]  = '{L,L,A40,Z,S0, H,L,A44,Z,S0, L,L,H,L, A44,Z,S0, DB,Z};
    tbl[10] = '{L,L,A40,Z,S0, H,L,A44,Z,S0, L,H,L,L, Z,Z,S0, DB,D33};
    tbl[11] = '{L,L,A40,Z,S0, H,L,A44,Z,S0, L,L,L,L, Z,Z,S0, DB,D33};
    // both held: grants alternate 0,1,0,1 with acks 3 cycles apart
    tbl[12] = '{H,L,A40,Z,S0, H,L,A44,Z,S0, L,L,H,L, A40,Z,S0, DB,D33};
    tbl[13] = '{H,L,A40,Z,S0, H,L,A44,Z,S0, H,L,L,L, Z,Z,S0, DB,D33};
    tbl[14] = '{H,L,A40,Z,S0, H,L,A44,Z,S0, L,L,L,L, Z,Z,S0, DB,D33};
    tbl[15] = '{H,L,A40,Z,S0, H,L,A44,Z,S0, L,L,H,L, A44,Z,S0, DB,D33};
    tbl[16] = '{H,L,A40,Z,S0, H,L,A44,Z,S0, L,H,L,L, Z,Z,S0, DB,D33};
    tbl[17] = '{H,L,A40,Z,S0, H,L,A44,Z,S0, L,L,L,L, Z,Z,S0, DB,D33};
    tbl[18] = '{H,L,A40,Z,S0, H,L,A44,Z,S0, L,L,H,L, A40,Z,S0, DB,D33};
    tbl[19] = '{H,L,A40,Z,S0, H,L,A44,Z,S0, H,L,L,L, Z,Z,S0, DB,D33};
    tbl[20] = '{H,L,A40,Z,S0, H,L,A44,Z,S0, L,L,L,L, Z,Z,S0, DB,D33};
    tbl[21] = '{H,L,A40,Z,S0, H,L,A44,Z,S0, L,L,H,L, A44,Z,S0, DB,D33};
    tbl[22] = '{L,L,A40,Z,S0, H,L,A44,Z,S0, L,H,L,L, Z,Z,S0, DB,D33};
    tbl[23] = '{L,L,A40,Z,S0, L,L,A44,Z,S0, L,L,L,L, Z,Z,S0, DB,D33};
    // m0 drops req during ISSUE: access completes, single ack, no repeat
    tbl[24] = '{H,L,A40,Z,S0, L,L,A44,Z,S0, L,L,H,L, A40,Z,S0, DB,D33};
    tbl[25] = '{L,L,A40,Z,S0, L,L,A44,Z,S0, H,L,L,L, Z,Z,S0, DB,D33};
    tbl[26] = '{L,L,A40,Z,S0, L,L,A44,Z,S0, L,L,L,L, Z,Z,S0, DB,D33};
    tbl[27] = '{L,L,A40,Z,S0, L,L,A44,Z,S0, L,L,L,L, Z,Z,S0, DB,D33};

    // Reset held with both masters requesting
    reset = 1'b0;
    m0_req = 1'b1; m0_write = 1'b1; m0_addr = A40; m0_wdata = DB; m0_sel = SF;
    m1_req = 1'b1; m1_write = 1'b1; m1_addr = A44; m1_wdata = D11; m1_sel = S2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_zero($sformatf("reset_hold%0d", i));
    end
    reset = 1'b1;  // released between edges; next edge is the first sample

    for (int i = 0; i < 28; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Reset during m1's write ISSUE cycle
    v = '{L,L,A40,Z,S0, H,H,A44,DFF,SF, L,L,L,H, A44,DFF,SF, DB,D33};
    apply("midrst_issue", v);
    #2 reset = 1'b0;
    #1 check_zero("midrst_async");
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    check_zero("midrst_noack");
    reset = 1'b1;

    // After release m0 wins the tie; the aborted write left 0x44 untouched
    v = '{H,L,A44,Z,S0, H,L,A40,Z,S0, L,L,H,L, A44,Z,S0, Z,Z};
    apply("post_rst_tie", v);
    v = '{H,L,A44,Z,S0, H,L,A40,Z,S0, H,L,L,L, Z,Z,S0, D33,Z};
    apply("post_rst_read", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
